// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: the raw button input plus the conditioned outputs.
// Ports: button_in (raw async input), level (debounced level), press/release_pulse/repeat_pulse (1-cycle events).
// release_pulse/repeat_pulse carry the release/repeat events; the bare words are SystemVerilog keywords.
interface button_conditioner_if;
  logic button_in;
  logic level;
  logic press;
  logic release_pulse;
  logic repeat_pulse;

  // master: whoever drives the raw button and consumes the events
  modport master (
    output button_in,
    input  level,
    input  press,
    input  release_pulse,
    input  repeat_pulse
  );

  // slave: the conditioner itself
  modport slave (
    input  button_in,
    output level,
    output press,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/button_conditioner.sv
// Conditions a raw async button into a debounced level plus press/release/auto-repeat pulses.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from a stable input change to level/press/release.
// Ports: clock, reset (sync, active-high), btn (slave modport: button_in in; level/press/release_pulse/repeat_pulse out).
module button_conditioner #(
  parameter int SYNC_STAGES     = 2,       // >= 2
  parameter int DEBOUNCE_CYCLES = 250000,  // >= 1
  parameter int CNT_WIDTH       = 18,      // 2**CNT_WIDTH > DEBOUNCE_CYCLES
  parameter int REPEAT_DELAY    = 0,       // 0 disables auto-repeat
  parameter int REPEAT_PERIOD   = 0,       // 0 gives a single repeat pulse per press
  parameter int REP_WIDTH       = 24       // must exceed both repeat parameters
) (
  input  logic                 clock,
  input  logic                 reset,
  button_conditioner_if.slave  btn
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHECK_HIGH  = 2'd1,
    STABLE_HIGH = 2'd2,
    CHECK_LOW   = 2'd3
  } state_t;

  // A single stable sample is enough: skip the CHECK states entirely.
  localparam bit SINGLE_SAMPLE = (DEBOUNCE_CYCLES == 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  localparam bit RPT_EN       = (REPEAT_DELAY != 0);
  localparam bit RPT_PERIODIC = (REPEAT_PERIOD != 0);
  localparam logic [REP_WIDTH-1:0] RPT_DELAY  = REP_WIDTH'(REPEAT_DELAY);
  // After a pulse the counter drops back by one period so the next hit on
  // RPT_DELAY lands exactly REPEAT_PERIOD cycles later. Assumes
  // REPEAT_PERIOD <= REPEAT_DELAY so the reload value is non-negative.
  localparam logic [REP_WIDTH-1:0] RPT_RELOAD = REP_WIDTH'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [REP_WIDTH-1:0] RPT_MAX    = {REP_WIDTH{1'b1}};

  // synchronizer
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;

  // debounce FSM
  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;

  // registered outputs and their next values
  logic level_q, press_q, release_q, repeat_q;
  logic level_next, press_next, release_next, repeat_next;

  // auto-repeat counter
  logic [REP_WIDTH-1:0] rc, rc_inc, rc_next;

  // Only the last synchronizer stage is ever looked at downstream.
  assign sync_q = sync_ff[SYNC_STAGES-1];

  //--------------------------------------------------------------------------
  // State registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_ff   <= '0;
      state     <= STABLE_LOW;
      cnt       <= '0;
      rc        <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], btn.button_in};
      state     <= state_next;
      cnt       <= cnt_next;
      rc        <= rc_next;
      level_q   <= level_next;
      press_q   <= press_next;
      release_q <= release_next;
      repeat_q  <= repeat_next;
    end
  end

  //--------------------------------------------------------------------------
  // Debounce FSM: level flips only after DEBOUNCE_CYCLES consecutive
  // samples disagreeing with it; any agreeing sample aborts the check.
  //--------------------------------------------------------------------------
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    level_next   = level_q;
    press_next   = 1'b0;
    release_next = 1'b0;

    case (state)
      STABLE_LOW: begin
        if (sync_q) begin
          if (SINGLE_SAMPLE) begin
            state_next = STABLE_HIGH;
            cnt_next   = '0;
            level_next = 1'b1;
            press_next = 1'b1;
          end else begin
            // this sample is the first of the run
            state_next = CHECK_HIGH;
            cnt_next   = CNT_WIDTH'(1);
          end
        end
      end

      CHECK_HIGH: begin
        if (!sync_q) begin
          state_next = STABLE_LOW;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      STABLE_HIGH: begin
        if (!sync_q) begin
          if (SINGLE_SAMPLE) begin
            state_next   = STABLE_LOW;
            cnt_next     = '0;
            level_next   = 1'b0;
            release_next = 1'b1;
          end else begin
            state_next = CHECK_LOW;
            cnt_next   = CNT_WIDTH'(1);
          end
        end
      end

      CHECK_LOW: begin
        if (sync_q) begin
          state_next = STABLE_HIGH;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next   = STABLE_LOW;
          cnt_next     = '0;
          level_next   = 1'b0;
          release_next = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end

      default: begin
        state_next = STABLE_LOW;
        cnt_next   = '0;
        level_next = 1'b0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Auto-repeat: counts cycles since the press while level is high (a bounce
  // through CHECK_LOW keeps counting). Saturates rather than wrapping so a
  // single-shot repeat (no period) cannot fire a second time.
  //--------------------------------------------------------------------------
  always_comb begin
    rc_inc = (rc == RPT_MAX) ? rc : rc + 1'b1;

    // Press only happens while level is low, so it can never collide with a
    // repeat; release can, and wins.
    repeat_next = RPT_EN && level_q && !release_next && (rc_inc == RPT_DELAY);

    if (!level_q || release_next) begin
      // covers the press cycle too: level_q is still low then
      rc_next = '0;
    end else if (repeat_next && RPT_PERIODIC) begin
      rc_next = RPT_RELOAD;
    end else begin
      rc_next = rc_inc;
    end
  end

  assign btn.level         = level_q;
  assign btn.press         = press_q;
  assign btn.release_pulse = release_q;
  assign btn.repeat_pulse  = repeat_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Testbench for button_conditioner: directed scenarios plus randomized button traffic.
// Expected outputs come from a cycle-level reference model and are queued per edge.
// A monitor pops one expectation each falling edge and compares all four outputs.
module tb_button_conditioner;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int CNT_WIDTH       = 4;
  localparam int REPEAT_DELAY    = 10;
  localparam int REPEAT_PERIOD   = 5;
  localparam int REP_WIDTH       = 8;

  logic clock = 1'b0;
  logic reset;

  button_conditioner_if bif ();

  button_conditioner #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_PERIOD  (REPEAT_PERIOD),
    .REP_WIDTH      (REP_WIDTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .btn  (bif)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic rpt;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Reference model state, in terms of observable behaviour:
  //   delay_line : raw input as seen through the synchronizer delay
  //   m_level    : current debounced level
  //   run        : consecutive samples disagreeing with m_level
  //   held       : cycles elapsed since the press edge
  bit delay_line[$];
  bit m_level;
  int run;
  int held;

  task automatic model_edge(input bit rst, input bit b);
    obs_t e;
    bit   s;
    e = '0;
    if (rst) begin
      delay_line = {};
      for (int i = 0; i < SYNC_STAGES; i++) delay_line.push_back(1'b0);
      m_level = 1'b0;
      run     = 0;
      held    = 0;
    end else begin
      s = delay_line.pop_front();
      delay_line.push_back(b);
      if (s != m_level) run++;
      else run = 0;
      if (run == DEBOUNCE_CYCLES) begin
        m_level = ~m_level;
        run     = 0;
        if (m_level) e.press = 1'b1;
        else         e.rel   = 1'b1;
      end
      if (e.press || e.rel) begin
        held = 0;
      end else if (m_level) begin
        held++;
        if (REPEAT_DELAY != 0) begin
          if (held == REPEAT_DELAY)
            e.rpt = 1'b1;
          else if (REPEAT_PERIOD != 0 && held > REPEAT_DELAY &&
                   ((held - REPEAT_DELAY) % REPEAT_PERIOD) == 0)
            e.rpt = 1'b1;
        end
      end
    end
    e.level = m_level;
    exp_q.push_back(e);
  endtask

  // Drive inputs for one edge (called at a falling edge), let the edge happen,
  // record the expectation, then return at the next falling edge.
  task automatic step(input bit rst, input bit b);
    reset         = rst;
    bif.button_in = b;
    @(posedge clock);
    model_edge(rst, b);
    @(negedge clock);
  endtask

  task automatic hold(input bit b, input int n);
    for (int i = 0; i < n; i++) step(1'b0, b);
  endtask

  // Monitor: outputs are registered, so one observation per cycle.
  initial begin
    obs_t e;
    obs_t a;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        cyc++;
        e = exp_q.pop_front();
        a = {bif.level, bif.press, bif.release_pulse, bif.repeat_pulse};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs @obs %0d: level/press/release/repeat got %b required %b",
                   cyc, a, e);
        end
      end
    end
  end

  initial begin
    int  len;
    int  nrst;
    bit  v;
    bit  b;

    reset         = 1'b1;
    bif.button_in = 1'b1;
    @(negedge clock);

    // reset held with button high, then released with button still high:
    // press on the 6th edge, repeats every 5 cycles from edge 16,
    // button drops after edge 40 so release lands on edge 46 together with
    // a due repeat (release must win)
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
    hold(1'b1, 40);
    hold(1'b0, 12);

    // bounce rejection: 3 high, 1 low, 3 high, low
    hold(1'b1, 3);
    hold(1'b0, 1);
    hold(1'b1, 3);
    hold(1'b0, 10);

    // boundary: a run of exactly DEBOUNCE_CYCLES-1 is rejected, exactly
    // DEBOUNCE_CYCLES is accepted
    hold(1'b1, DEBOUNCE_CYCLES - 1);
    hold(1'b0, 8);
    hold(1'b1, DEBOUNCE_CYCLES);
    hold(1'b0, DEBOUNCE_CYCLES - 1);
    hold(1'b1, 6);
    hold(1'b0, 10);

    // reset in the middle of a high check, button kept high throughout
    hold(1'b1, 4);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    hold(1'b1, 14);

    // reset in the middle of auto-repeat
    step(1'b1, 1'b1);
    hold(1'b0, 8);

    // randomized traffic: hold phases with occasional single-sample glitches
    // and occasional resets
    for (int p = 0; p < 150; p++) begin
      len = $urandom_range(1, 40);
      v   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        nrst = $urandom_range(1, 3);
        for (int i = 0; i < nrst; i++) step(1'b1, v);
      end
      for (int i = 0; i < len; i++) begin
        b = v ^ ($urandom_range(0, 11) == 0);
        step(1'b0, b);
      end
    end
    hold(1'b0, 10);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
